// File: rtl/ttl_counter_pkg.sv
// Shared types and helpers for the TTL-style counter bank.
// The mode enum, the legal parameter ranges, and the top-value function live here.
package ttl_counter_pkg;

  typedef enum logic {
    MODE_BIN = 1'b0,
    MODE_DEC = 1'b1
  } mode_e;

  localparam int MIN_CHANNELS = 1;
  localparam int MAX_CHANNELS = 8;
  localparam int MIN_WIDTH    = 2;
  localparam int MAX_WIDTH    = 16;
  localparam int MIN_DEC_MOD  = 2;

  // Last count value before a roll-over in the given mode.
  function automatic int unsigned top_value(input mode_e       mode,
                                            input int unsigned width,
                                            input int unsigned dec_mod);
    return (mode == MODE_DEC) ? dec_mod - 1 : (32'd1 << width) - 1;
  endfunction

endpackage

// File: rtl/ttl_counter_bank_if.sv
// Per-channel count/clear/mode inputs and count/status outputs of the counter bank.
// The casc vector exists only when CASCADE_EN is defined.
interface ttl_counter_bank_if #(
  parameter int CHANNELS = 2,
  parameter int WIDTH    = 4
);
  logic [CHANNELS-1:0]       a;
  logic [CHANNELS-1:0]       clr;
  logic [CHANNELS-1:0]       dec;
`ifdef CASCADE_EN
  logic [CHANNELS-1:0]       casc;
`endif
  logic [CHANNELS*WIDTH-1:0] q;
  logic [CHANNELS-1:0]       tc;
  logic [CHANNELS-1:0]       wrap;

`ifdef CASCADE_EN
  modport master (output a, clr, dec, casc, input  q, tc, wrap);
  modport slave  (input  a, clr, dec, casc, output q, tc, wrap);
`else
  modport master (output a, clr, dec, input  q, tc, wrap);
  modport slave  (input  a, clr, dec, output q, tc, wrap);
`endif
endinterface

// File: rtl/ttl_counter_chan.sv
// One counter channel: falling-edge detect on a, binary/decade roll-over, sync clear.
// carry is the same-cycle wrap event that a cascaded neighbour counts on.
module ttl_counter_chan
  import ttl_counter_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int DEC_MOD = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             a,
  input  logic             clr,
  input  mode_e            mode,
  input  logic             ext_sel,
  input  logic             ext_evt,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             wrap,
  output logic             carry
);

  logic             a_q;
  logic             evt;
  logic [WIDTH-1:0] top;

  always_comb begin
    top = WIDTH'(top_value(mode, WIDTH, DEC_MOD));
  end

  assign evt   = ext_sel ? ext_evt : (a_q & ~a);
  // q >= top (not ==) so a count left above a freshly lowered top still rolls to 0.
  assign carry = evt & ~clr & (q >= top);
  assign tc    = (q == top);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q  <= 1'b0;
      q    <= '0;
      wrap <= 1'b0;
    end else begin
      a_q  <= a;
      wrap <= carry;
      if (clr) begin
        q <= '0;
      end else if (evt) begin
        q <= (q >= top) ? '0 : q + WIDTH'(1);
      end
    end
  end

endmodule

// File: rtl/ttl_counter_bank.sv
// Bank of CHANNELS independent counters; optional CASCADE_EN lets channel i
// count on channel i-1's combinational wrap instead of its own a input.
module ttl_counter_bank
  import ttl_counter_pkg::*;
#(
  parameter int CHANNELS = 2,
  parameter int WIDTH    = 4,
  parameter int DEC_MOD  = 10
) (
  input  logic               clk,
  input  logic               rst_n,
  ttl_counter_bank_if.slave  bus
);

  if (CHANNELS < MIN_CHANNELS || CHANNELS > MAX_CHANNELS) begin : g_bad_channels
    $error("ttl_counter_bank: CHANNELS out of range 1..8");
  end
  if (WIDTH < MIN_WIDTH || WIDTH > MAX_WIDTH) begin : g_bad_width
    $error("ttl_counter_bank: WIDTH out of range 2..16");
  end
  if (DEC_MOD < MIN_DEC_MOD || DEC_MOD > (1 << WIDTH)) begin : g_bad_dec_mod
    $error("ttl_counter_bank: DEC_MOD out of range 2..2**WIDTH");
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    logic ext_sel;
    logic ext_evt;
    logic carry;

    if (i == 0) begin : g_head
      assign ext_sel = 1'b0;
      assign ext_evt = 1'b0;
    end else begin : g_link
      // Per-block carry signals keep the chain free of a self-referencing vector.
      assign ext_evt = g_chan[i-1].carry;
`ifdef CASCADE_EN
      assign ext_sel = bus.casc[i];
`else
      assign ext_sel = 1'b0;
`endif
    end

    ttl_counter_chan #(
      .WIDTH   (WIDTH),
      .DEC_MOD (DEC_MOD)
    ) u_chan (
      .clk     (clk),
      .rst_n   (rst_n),
      .a       (bus.a[i]),
      .clr     (bus.clr[i]),
      .mode    (mode_e'(bus.dec[i])),
      .ext_sel (ext_sel),
      .ext_evt (ext_evt),
      .q       (bus.q[i*WIDTH +: WIDTH]),
      .tc      (bus.tc[i]),
      .wrap    (bus.wrap[i]),
      .carry   (carry)
    );
  end

  logic unused_last_carry;
  assign unused_last_carry = g_chan[CHANNELS-1].carry;

`ifdef CASCADE_EN
  logic unused_casc0;
  assign unused_casc0 = bus.casc[0];
`endif

endmodule

// File: tb/tb_ttl_counter_bank.sv
// Self-checking bench for ttl_counter_bank: reference model feeds a scoreboard
// queue each cycle; cascade scenario runs only when CASCADE_EN is defined.
module tb_ttl_counter_bank;

  localparam int CH      = 2;
  localparam int W       = 4;
  localparam int DEC_MOD = 10;
`ifdef CASCADE_EN
  localparam bit CASC_ON = 1'b1;
`else
  localparam bit CASC_ON = 1'b0;
`endif

  typedef struct {
    logic [CH*W-1:0] q;
    logic [CH-1:0]   tc;
    logic [CH-1:0]   wrap;
  } exp_t;

  logic clk;
  logic rst_n;
  ttl_counter_bank_if #(.CHANNELS(CH), .WIDTH(W)) bus ();

  ttl_counter_bank #(
    .CHANNELS (CH),
    .WIDTH    (W),
    .DEC_MOD  (DEC_MOD)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  exp_t sb[$];
  int   n_cmp;
  int   n_err;
  int   m_q  [CH];
  bit   m_aq [CH];
  int   wraps [CH];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int top_of(input bit dec);
    return dec ? DEC_MOD - 1 : (1 << W) - 1;
  endfunction

  task automatic model_reset();
    for (int c = 0; c < CH; c++) begin
      m_q[c]  = 0;
      m_aq[c] = 1'b0;
    end
  endtask

  // Drive one cycle of inputs at the falling edge, predict, then compare after the rising edge.
  task automatic cycle(input logic [CH-1:0] a, input logic [CH-1:0] clr,
                       input logic [CH-1:0] dec, input logic [CH-1:0] casc);
    exp_t e;
    exp_t got;
    bit   carry [CH];
    bit   evt;
    @(negedge clk);
    bus.a   = a;
    bus.clr = clr;
    bus.dec = dec;
`ifdef CASCADE_EN
    bus.casc = casc;
`endif
    for (int c = 0; c < CH; c++) begin
      evt = m_aq[c] & ~a[c];
      if (CASC_ON && c > 0 && casc[c]) evt = carry[c-1];
      carry[c] = evt && !clr[c] && (m_q[c] >= top_of(dec[c]));
      if (clr[c])     m_q[c] = 0;
      else if (evt)   m_q[c] = carry[c] ? 0 : m_q[c] + 1;
      m_aq[c] = a[c];
      e.q[c*W +: W] = W'(m_q[c]);
      e.tc[c]       = (m_q[c] == top_of(dec[c]));
      e.wrap[c]     = carry[c];
    end
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      check("sb_empty", 32'd1, 32'd0);
    end else begin
      got = sb.pop_front();
      check("q",    32'(bus.q),    32'(got.q));
      check("tc",   32'(bus.tc),   32'(got.tc));
      check("wrap", 32'(bus.wrap), 32'(got.wrap));
    end
    for (int c = 0; c < CH; c++) if (bus.wrap[c] === 1'b1) wraps[c]++;
  endtask

  // One falling edge on the selected channels (high cycle then low cycle).
  task automatic edge_on(input logic [CH-1:0] m, input logic [CH-1:0] dec, input logic [CH-1:0] casc);
    cycle(m, '0, dec, casc);
    cycle('0, '0, dec, casc);
  endtask

  task automatic clear_all(input logic [CH-1:0] dec);
    cycle('0, '1, dec, '0);
    for (int c = 0; c < CH; c++) wraps[c] = 0;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    for (int c = 0; c < CH; c++) wraps[c] = 0;
    rst_n   = 1'b0;
    bus.a   = '0;
    bus.clr = '0;
    bus.dec = '0;
`ifdef CASCADE_EN
    bus.casc = '0;
`endif
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_q",    32'(bus.q),    32'd0);
    check("rst_tc",   32'(bus.tc),   32'd0);
    check("rst_wrap", 32'(bus.wrap), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Binary: 16 edges on channel 0 -> 1..15 then 0, one wrap.
    for (int k = 0; k < 16; k++) edge_on(2'b01, 2'b00, 2'b00);
    check("bin_q0_final", 32'(bus.q[W-1:0]), 32'd0);
    check("bin_wraps",    32'(wraps[0]),     32'd1);

    // Decade: 12 edges -> ends at 2, one wrap.
    clear_all(2'b01);
    for (int k = 0; k < 12; k++) edge_on(2'b01, 2'b01, 2'b00);
    check("dec_q0_final", 32'(bus.q[W-1:0]), 32'd2);
    check("dec_wraps",    32'(wraps[0]),     32'd1);

    // Clear wins over a simultaneous count event.
    clear_all(2'b00);
    for (int k = 0; k < 7; k++) edge_on(2'b01, 2'b00, 2'b00);
    check("clr_pre_q0", 32'(bus.q[W-1:0]), 32'd7);
    cycle(2'b01, 2'b00, 2'b00, 2'b00);
    cycle(2'b00, 2'b01, 2'b00, 2'b00);
    check("clr_q0",    32'(bus.q[W-1:0]), 32'd0);
    check("clr_wraps", 32'(wraps[0]),     32'd0);
    edge_on(2'b01, 2'b00, 2'b00);
    check("clr_next_q0", 32'(bus.q[W-1:0]), 32'd1);

    // Count above decade top, then switch to decade.
    clear_all(2'b00);
    for (int k = 0; k < 13; k++) edge_on(2'b01, 2'b00, 2'b00);
    cycle(2'b00, 2'b00, 2'b01, 2'b00);
    check("above_top_tc0", 32'(bus.tc[0]), 32'd0);
    cycle(2'b01, 2'b00, 2'b01, 2'b00);
    cycle(2'b00, 2'b00, 2'b01, 2'b00);
    check("above_top_q0",   32'(bus.q[W-1:0]), 32'd0);
    check("above_top_wrap", 32'(bus.wrap[0]),  32'd1);

    // Both channels, simultaneous edges, mixed modes.
    clear_all(2'b10);
    for (int k = 0; k < 11; k++) edge_on(2'b11, 2'b10, 2'b00);
    check("dual_q0", 32'(bus.q[W-1:0]), 32'd11);
    check("dual_q1", 32'(bus.q[W +: W]), 32'd1);

`ifdef CASCADE_EN
    // Decade cascade: 20 edges on a[0] -> q0=0, q1=2; a[1] toggles have no effect.
    clear_all(2'b11);
    for (int k = 0; k < 20; k++) begin
      cycle({k[0], 1'b1}, 2'b00, 2'b11, 2'b10);
      cycle({~k[0], 1'b0}, 2'b00, 2'b11, 2'b10);
    end
    check("casc_q0",    32'(bus.q[W-1:0]), 32'd0);
    check("casc_q1",    32'(bus.q[W +: W]), 32'd2);
    check("casc_wrap1", 32'(wraps[1]),      32'd0);
`endif

    // Random mix of inputs across both channels.
    for (int k = 0; k < 200; k++) begin
      cycle(CH'($urandom), ($urandom_range(0, 15) == 0) ? CH'($urandom) : '0,
            CH'($urandom_range(0, 3) == 0 ? $urandom : bus.dec), CH'($urandom));
    end

    // Asynchronous reset mid-count with a held low.
    clear_all(2'b00);
    for (int k = 0; k < 5; k++) edge_on(2'b01, 2'b00, 2'b00);
    check("mid_pre_q0", 32'(bus.q[W-1:0]), 32'd5);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_q",    32'(bus.q),    32'd0);
    check("mid_rst_wrap", 32'(bus.wrap), 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    cycle(2'b00, 2'b00, 2'b00, 2'b00);
    check("mid_rel_q0", 32'(bus.q[W-1:0]), 32'd0);
    edge_on(2'b01, 2'b00, 2'b00);
    check("mid_first_q0", 32'(bus.q[W-1:0]), 32'd1);

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish, limit 500000");
    $fatal(1, "timeout");
  end

endmodule
